// File: rtl/add_16_bit.sv
// 16-bit ripple-carry adder: a chain of full adders, LSB first.
module add_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carryIn,
  output logic [15:0] sum,
  output logic        carryOut
);

  logic [16:0] carry;

  assign carry[0] = carryIn;

  for (genvar i = 0; i < 16; i++) begin : gen_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carryOut = carry[16];

endmodule

// File: rtl/mul_16_bit_seq.sv
// Sequential shift-and-add unsigned multiplier, 16x16 -> 32.
// One partial product per cycle through add_16_bit; valid/ready on both sides.
module mul_16_bit_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  // The datapath is hard-wired to the 16-bit adder.
  if (WIDTH != 16) begin : gen_width_check
    $error("mul_16_bit_seq supports only WIDTH == 16");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state;
  state_e      stateNext;
  logic [15:0] mcand;
  logic [15:0] hi;
  logic [15:0] lo;
  logic [3:0]  cnt;
  logic [31:0] productReg;
  logic        outValidReg;

  logic [15:0] addB;
  logic [15:0] sum;
  logic        carryOut;
  logic [31:0] shifted;

  // Add the multiplicand to the accumulator when the current multiplier bit is set.
  assign addB = lo[0] ? mcand : 16'h0000;

  add_16_bit u_add (
    .a        (hi),
    .b        (addB),
    .carryIn  (1'b0),
    .sum      (sum),
    .carryOut (carryOut)
  );

  // 33-bit {carry, sum, lo} shifted right by one; lo[0] has been consumed.
  assign shifted = {carryOut, sum, lo[15:1]};

  // Next-state decode.
  always_comb begin
    stateNext = state;
    unique case (state)
      StIdle:  if (in_valid) stateNext = StRun;
      StRun:   if (cnt == 4'd15) stateNext = StDone;
      StDone:  if (out_ready) stateNext = StIdle;
      default: stateNext = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
    end else begin
      state <= stateNext;
    end
  end

  // Operand capture, iteration datapath and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand       <= 16'h0000;
      hi          <= 16'h0000;
      lo          <= 16'h0000;
      cnt         <= 4'd0;
      productReg  <= 32'h0000_0000;
      outValidReg <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            mcand <= a;
            lo    <= b;
            hi    <= 16'h0000;
            cnt   <= 4'd0;
          end
        end
        StRun: begin
          {hi, lo} <= shifted;
          cnt      <= cnt + 4'd1;
          // Result register only loads on the final iteration so it holds outside DONE.
          if (cnt == 4'd15) begin
            productReg  <= shifted;
            outValidReg <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) outValidReg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == StIdle);
  assign out_valid = outValidReg;
  assign product   = productReg;

endmodule
